el2_ifu_iccm_arb: RTL and testbench
===================================

Name: el2_ifu_iccm_arb

Overview:
Single-port request arbiter and sequencer in front of the ICCM memory wrapper. It shares the one ICCM read/write port between three requesters: IFU instruction fetch, DMA, and the ECC single-bit correction write-back. It registers the winning command onto the ICCM port and routes read data back to the requester that issued the read. It also sequences the correction write-back, driving iccm_buf_correct_ecc and iccm_correction_state.

Parameters:
ICCM_BITS, 16, ICCM byte-address width; request addresses are [ICCM_BITS-1:1]
RD_LATENCY, 1, cycles from iccm_rden to valid iccm_rd_data (range 1..3)
DMA_MAX_WAIT, 4, cycles DMA may be refused before it outranks fetch (range 1..15)

Ports:
clk  in  1  core clock
rst_l  in  1  synchronous active-low reset
ifu_req_valid  in  1  fetch read request
ifu_req_ready  out  1  fetch request accepted this cycle
ifu_req_addr  in  ICCM_BITS-1  fetch address [ICCM_BITS-1:1]
dma_req_valid  in  1  DMA request
dma_req_ready  out  1  DMA request accepted this cycle
dma_req_write  in  1  1 = write, 0 = read
dma_req_addr  in  ICCM_BITS-1  DMA address
dma_req_size  in  3  DMA write size
dma_req_wdata  in  78  DMA write data with ECC
corr_req_valid  in  1  correction write-back request
corr_req_ready  out  1  correction accepted
corr_req_addr  in  ICCM_BITS-1  address to correct
corr_req_wdata  in  78  corrected data with ECC
iccm_rden  out  1  ICCM read enable
iccm_wren  out  1  ICCM write enable
iccm_rw_addr  out  ICCM_BITS-1  ICCM address
iccm_wr_size  out  3  ICCM write size
iccm_wr_data  out  78  ICCM write data
iccm_buf_correct_ecc  out  1  correction write in progress
iccm_correction_state  out  1  arbiter in correction sequence
iccm_rd_data  in  64  ICCM read data
ifu_rsp_valid  out  1  fetch read data valid
dma_rsp_valid  out  1  DMA read data valid
rsp_data  out  64  read data, pass-through of iccm_rd_data
arb_busy  out  1  a command or read response is outstanding

Behaviour:
- Reset: all outputs are 0. The FSM goes to IDLE, the aging counter clears, and the response pipe clears. This takes effect on the first rising clk edge with rst_l=0.
- Reset mid-operation: in-flight reads are discarded, so no rsp_valid follows reset.

FSM states:
- IDLE: readies may assert.
- CORR_WR: exactly one cycle. iccm_wren=1, iccm_buf_correct_ecc=1, iccm_correction_state=1, iccm_wr_size=3'b010. Address and data come from the captured corr request.
- CORR_HOLD: exactly one cycle. iccm_correction_state=1, no ICCM command. Then return to IDLE.
- In CORR_WR and CORR_HOLD all readies are 0.

Arbitration in IDLE:
- Readies are combinational; at most one ready is asserted per cycle.
- Priority order: corr > DMA (when aged) > fetch > DMA.
- DMA is "aged" when dma_wait_cnt == DMA_MAX_WAIT.
- A corr handshake in IDLE moves the FSM to CORR_WR on the next cycle.

DMA aging counter (dma_wait_cnt, 4 bits, saturating):
- Increments when dma_req_valid=1 and dma_req_ready=0.
- Clears on a DMA handshake or when dma_req_valid=0.

Command timing:
- A fetch or DMA handshake in cycle N drives registered iccm_rden/iccm_wren, addr, size and data in cycle N+1, each for one cycle.
- A fetch is always a read.
- A DMA request uses wren if dma_req_write=1, otherwise rden.
- In cycles without a command, rden and wren are 0. Addr, data and size hold their last value.

Read return:
- An owner tag (ifu or dma) is shifted through a RD_LATENCY-deep pipe.
- ifu_rsp_valid or dma_rsp_valid asserts in cycle N+1+RD_LATENCY, with rsp_data = iccm_rd_data.
- Responses return in order. Writes produce no response.

Throughput:
- Back-to-back fetch or DMA grants are allowed every cycle.
- A correction costs 2 port cycles.

Other rules:
- Simultaneous valid on all three requesters: corr wins. Fetch and DMA wait and are not dropped; the DMA counter keeps aging.
- Requesters must hold valid and payload until ready.
- arb_busy = command register valid, or any pipe entry valid, or FSM != IDLE.

Test Plan:
- Fetch read: ifu_req_valid with addr 0x0100, handshake in cycle N.
  -> iccm_rden=1 with iccm_rw_addr=0x0100 in N+1.
  -> ifu_rsp_valid=1 with rsp_data=0xDEADBEEF_CAFEF00D in N+2 (RD_LATENCY=1).
- Fetch vs DMA contention: fetch valid and DMA read valid every cycle, DMA_MAX_WAIT=4.
  -> fetch granted 4 cycles, DMA granted on the 5th, counter back to 0, then fetch resumes.
- Correction vs fetch: corr (addr 0x0040) and fetch valid together.
  -> corr_req_ready=1.
  -> next cycle: wren=1, buf_correct_ecc=1, correction_state=1, addr 0x0040.
  -> next cycle: correction_state only.
  -> ifu_req_ready stays low for those 2 cycles, then fetch is granted.
- DMA write: dma_req_write=1, size 3'b010, wdata 78'h3_1234_5678_9ABC_DEF0.
  -> wren=1 with matching size and data one cycle later; no rsp_valid.
- Reset in flight: fetch read granted, rst_l=0 in the cycle rden is high.
  -> no ifu_rsp_valid afterwards; all outputs 0 after the edge.
- Streaming: fetch valid for 8 consecutive cycles.
  -> rden high 8 consecutive cycles, 8 consecutive ifu_rsp_valid, data in order.

Source files
------------

// File: rtl/el2_ifu_iccm_arb.sv
// Shares the single ICCM port between fetch, DMA and ECC correction write-back.
// Registers the winning command and tags read returns back to their requester.
module el2_ifu_iccm_arb #(
  parameter int ICCM_BITS    = 16,
  parameter int RD_LATENCY   = 1,
  parameter int DMA_MAX_WAIT = 4
) (
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic                   ifu_req_valid,
  output logic                   ifu_req_ready,
  input  logic [ICCM_BITS-1:1]   ifu_req_addr,
  input  logic                   dma_req_valid,
  output logic                   dma_req_ready,
  input  logic                   dma_req_write,
  input  logic [ICCM_BITS-1:1]   dma_req_addr,
  input  logic [2:0]             dma_req_size,
  input  logic [77:0]            dma_req_wdata,
  input  logic                   corr_req_valid,
  output logic                   corr_req_ready,
  input  logic [ICCM_BITS-1:1]   corr_req_addr,
  input  logic [77:0]            corr_req_wdata,
  output logic                   iccm_rden,
  output logic                   iccm_wren,
  output logic [ICCM_BITS-1:1]   iccm_rw_addr,
  output logic [2:0]             iccm_wr_size,
  output logic [77:0]            iccm_wr_data,
  output logic                   iccm_buf_correct_ecc,
  output logic                   iccm_correction_state,
  input  logic [63:0]            iccm_rd_data,
  output logic                   ifu_rsp_valid,
  output logic                   dma_rsp_valid,
  output logic [63:0]            rsp_data,
  output logic                   arb_busy
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] CORR_WR   = 2'd1;
  localparam logic [1:0] CORR_HOLD = 2'd2;

  localparam logic [3:0] MAX_WAIT  = 4'(DMA_MAX_WAIT);

  logic [1:0]            state_q, state_d;
  logic [3:0]            dma_wait_q, dma_wait_d;
  logic                  cmd_rden_q, cmd_wren_q, cmd_ifu_q;
  logic [ICCM_BITS-1:1]  addr_q;
  logic [2:0]            size_q;
  logic [77:0]           wdata_q;
  logic [RD_LATENCY-1:0] pipe_ifu_q, pipe_dma_q;

  logic idle, dma_aged, ifu_hs, dma_hs, corr_hs;

  always_comb begin
    idle     = rst_l && (state_q == IDLE);
    dma_aged = (dma_wait_q == MAX_WAIT);

    corr_req_ready = idle && corr_req_valid;
    dma_req_ready  = idle && !corr_req_valid && dma_req_valid && (dma_aged || !ifu_req_valid);
    ifu_req_ready  = idle && !corr_req_valid && ifu_req_valid && !(dma_req_valid && dma_aged);

    corr_hs = corr_req_ready;
    dma_hs  = dma_req_ready;
    ifu_hs  = ifu_req_ready;

    // Counter stops at the aging threshold so an equality test cannot be skipped
    // past while the port is tied up by a correction.
    dma_wait_d = '0;
    if (dma_req_valid && !dma_req_ready)
      dma_wait_d = (dma_wait_q == MAX_WAIT) ? dma_wait_q : dma_wait_q + 4'd1;

    state_d = IDLE;
    case (state_q)
      IDLE:      state_d = corr_hs ? CORR_WR : IDLE;
      CORR_WR:   state_d = CORR_HOLD;
      CORR_HOLD: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q    <= IDLE;
      dma_wait_q <= '0;
      cmd_rden_q <= 1'b0;
      cmd_wren_q <= 1'b0;
      cmd_ifu_q  <= 1'b0;
      addr_q     <= '0;
      size_q     <= '0;
      wdata_q    <= '0;
      pipe_ifu_q <= '0;
      pipe_dma_q <= '0;
    end else begin
      state_q    <= state_d;
      dma_wait_q <= dma_wait_d;
      cmd_rden_q <= ifu_hs || (dma_hs && !dma_req_write);
      cmd_wren_q <= corr_hs || (dma_hs && dma_req_write);
      cmd_ifu_q  <= ifu_hs;

      if (corr_hs) begin
        addr_q  <= corr_req_addr;
        size_q  <= 3'b010;
        wdata_q <= corr_req_wdata;
      end else if (dma_hs) begin
        addr_q <= dma_req_addr;
        if (dma_req_write) begin
          size_q  <= dma_req_size;
          wdata_q <= dma_req_wdata;
        end
      end else if (ifu_hs) begin
        addr_q <= ifu_req_addr;
      end

      // Owner tag rides alongside the read so returns need no address matching.
      pipe_ifu_q[0] <= cmd_rden_q && cmd_ifu_q;
      pipe_dma_q[0] <= cmd_rden_q && !cmd_ifu_q;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        pipe_ifu_q[i] <= pipe_ifu_q[i-1];
        pipe_dma_q[i] <= pipe_dma_q[i-1];
      end
    end
  end

  always_comb begin
    iccm_rden             = cmd_rden_q;
    iccm_wren             = cmd_wren_q;
    iccm_rw_addr          = addr_q;
    iccm_wr_size          = size_q;
    iccm_wr_data          = wdata_q;
    iccm_buf_correct_ecc  = (state_q == CORR_WR);
    iccm_correction_state = (state_q != IDLE);
    ifu_rsp_valid         = pipe_ifu_q[RD_LATENCY-1];
    dma_rsp_valid         = pipe_dma_q[RD_LATENCY-1];
    rsp_data              = iccm_rd_data;
    arb_busy              = cmd_rden_q || cmd_wren_q || (|pipe_ifu_q) || (|pipe_dma_q) ||
                            (state_q != IDLE);
  end

endmodule

// File: tb/tb_el2_ifu_iccm_arb.sv
// Randomised bench for el2_ifu_iccm_arb with a cycle-level reference model
// and a small memory responder; directed sequences pin the model with literals.
module tb_el2_ifu_iccm_arb;

  localparam int ICCM_BITS = 16;
  localparam int RDL       = 1;
  localparam int MAXW      = 4;

  logic        clk, rst_l;
  logic        ifu_req_valid, ifu_req_ready;
  logic [14:0] ifu_req_addr;
  logic        dma_req_valid, dma_req_ready, dma_req_write;
  logic [14:0] dma_req_addr;
  logic [2:0]  dma_req_size;
  logic [77:0] dma_req_wdata;
  logic        corr_req_valid, corr_req_ready;
  logic [14:0] corr_req_addr;
  logic [77:0] corr_req_wdata;
  logic        iccm_rden, iccm_wren;
  logic [14:0] iccm_rw_addr;
  logic [2:0]  iccm_wr_size;
  logic [77:0] iccm_wr_data;
  logic        iccm_buf_correct_ecc, iccm_correction_state;
  logic [63:0] iccm_rd_data;
  logic        ifu_rsp_valid, dma_rsp_valid;
  logic [63:0] rsp_data;
  logic        arb_busy;

  el2_ifu_iccm_arb #(.ICCM_BITS(ICCM_BITS), .RD_LATENCY(RDL), .DMA_MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst_l(rst_l),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready), .dma_req_write(dma_req_write),
    .dma_req_addr(dma_req_addr), .dma_req_size(dma_req_size), .dma_req_wdata(dma_req_wdata),
    .corr_req_valid(corr_req_valid), .corr_req_ready(corr_req_ready),
    .corr_req_addr(corr_req_addr), .corr_req_wdata(corr_req_wdata),
    .iccm_rden(iccm_rden), .iccm_wren(iccm_wren), .iccm_rw_addr(iccm_rw_addr),
    .iccm_wr_size(iccm_wr_size), .iccm_wr_data(iccm_wr_data),
    .iccm_buf_correct_ecc(iccm_buf_correct_ecc), .iccm_correction_state(iccm_correction_state),
    .iccm_rd_data(iccm_rd_data), .ifu_rsp_valid(ifu_rsp_valid), .dma_rsp_valid(dma_rsp_valid),
    .rsp_data(rsp_data), .arb_busy(arb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] memf(input logic [14:0] a);
    if (a == 15'h0100) return 64'hDEADBEEF_CAFEF00D;
    return {a, 1'b1, ~a, 1'b0, a ^ 15'h2A5A, 2'b01, ~a ^ 15'h1234};
  endfunction

  // ---------------- reference model ----------------
  typedef struct { int c; bit ifu; logic [14:0] a; } rsp_t;
  rsp_t        rq[$];
  int          cyc = 0;
  bit          armed = 0;
  int          m_phase = 0;   // 0 free, 1 correction write cycle, 2 correction hold cycle
  int          m_wait = 0;
  logic        e_rden = 0, e_wren = 0, e_bufecc = 0, e_corrst = 0;
  logic [14:0] e_addr = '0;
  logic [2:0]  e_size = '0;
  logic [77:0] e_data = '0;
  bit          g_c, g_d, g_f, m_idle, x_ifu, x_dma, pend;
  logic [63:0] x_data;
  logic        h_rden [8];
  logic [14:0] h_addr [8];
  logic [63:0] rd_next = '0;

  always @(negedge clk) begin
    m_idle = rst_l && (m_phase == 0);
    g_c = m_idle && corr_req_valid;
    g_d = m_idle && !corr_req_valid && dma_req_valid && (m_wait >= MAXW || !ifu_req_valid);
    g_f = m_idle && !corr_req_valid && ifu_req_valid && !g_d;

    if (armed) begin
      chk("rden", 128'(iccm_rden), 128'(e_rden));
      chk("wren", 128'(iccm_wren), 128'(e_wren));
      chk("buf_correct_ecc", 128'(iccm_buf_correct_ecc), 128'(e_bufecc));
      chk("correction_state", 128'(iccm_correction_state), 128'(e_corrst));
      if (e_rden || e_wren) chk("rw_addr", 128'(iccm_rw_addr), 128'(e_addr));
      if (e_wren) begin
        chk("wr_size", 128'(iccm_wr_size), 128'(e_size));
        chk("wr_data", 128'(iccm_wr_data), 128'(e_data));
      end
      pend = (rq.size() > 0);
      x_ifu = 0; x_dma = 0; x_data = '0;
      if (pend && rq[0].c == cyc) begin
        x_ifu  = rq[0].ifu;
        x_dma  = !rq[0].ifu;
        x_data = memf(rq[0].a);
        void'(rq.pop_front());
      end
      chk("rsp_valid", 128'({ifu_rsp_valid, dma_rsp_valid}), 128'({x_ifu, x_dma}));
      if (x_ifu || x_dma) chk("rsp_data", 128'(rsp_data), 128'(x_data));
      chk("arb_busy", 128'(arb_busy), 128'(e_rden || e_wren || pend || m_phase != 0));
      chk("readies", 128'({corr_req_ready, dma_req_ready, ifu_req_ready}), 128'({g_c, g_d, g_f}));
    end

    if (!rst_l) begin
      armed = 1; rq.delete(); m_phase = 0; m_wait = 0;
      e_rden = 0; e_wren = 0; e_bufecc = 0; e_corrst = 0;
      e_addr = '0; e_size = '0; e_data = '0;
    end else begin
      e_rden = g_f || (g_d && !dma_req_write);
      e_wren = g_c || (g_d && dma_req_write);
      if (g_c) begin
        e_addr = corr_req_addr; e_size = 3'b010; e_data = corr_req_wdata;
      end else if (g_d) begin
        e_addr = dma_req_addr;
        if (dma_req_write) begin e_size = dma_req_size; e_data = dma_req_wdata; end
      end else if (g_f) begin
        e_addr = ifu_req_addr;
      end
      if (e_rden) rq.push_back('{cyc + 1 + RDL, g_f, e_addr});
      m_wait  = (dma_req_valid && !g_d) ? ((m_wait < 15) ? m_wait + 1 : 15) : 0;
      m_phase = g_c ? 1 : (m_phase == 1) ? 2 : 0;
      e_bufecc = (m_phase == 1);
      e_corrst = (m_phase != 0);
    end

    // memory responder: data for the read issued RDL cycles before next cycle
    h_rden[cyc % 8] = iccm_rden;
    h_addr[cyc % 8] = iccm_rw_addr;
    if (cyc + 1 - RDL >= 0 && h_rden[(cyc + 1 - RDL) % 8] === 1'b1)
      rd_next = memf(h_addr[(cyc + 1 - RDL) % 8]);
    else
      rd_next = {$urandom(), $urandom()};
    cyc++;
  end

  initial begin
    iccm_rd_data = '0;
    forever begin
      @(posedge clk); #1;
      iccm_rd_data = rd_next;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    ifu_req_valid = 0; dma_req_valid = 0; corr_req_valid = 0; dma_req_write = 0;
  endtask

  logic [9:0]  pat_d, pat_f;
  logic [11:0] pat_rden, pat_rsp;
  bit          f_fired, d_fired, c_fired;

  initial begin
    rst_l = 0; idle_inputs();
    ifu_req_addr = '0; dma_req_addr = '0; dma_req_size = '0; dma_req_wdata = '0;
    corr_req_addr = '0; corr_req_wdata = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_ctl", 128'({ifu_req_ready, dma_req_ready, corr_req_ready, iccm_rden, iccm_wren,
        iccm_buf_correct_ecc, iccm_correction_state, ifu_rsp_valid, dma_rsp_valid, arb_busy}), 128'(0));
    chk("reset_data", 128'({iccm_rw_addr, iccm_wr_size, iccm_wr_data}), 128'(0));

    // single fetch read
    tick(); rst_l = 1; ifu_req_valid = 1; ifu_req_addr = 15'h0100;
    @(negedge clk); chk("fetch_ready", 128'(ifu_req_ready), 128'(1));
    tick(); ifu_req_valid = 0;
    @(negedge clk); chk("fetch_cmd", 128'({iccm_rden, iccm_rw_addr}), 128'({1'b1, 15'h0100}));
    tick();
    @(negedge clk); chk("fetch_rsp", 128'({ifu_rsp_valid, rsp_data}), 128'({1'b1, 64'hDEADBEEF_CAFEF00D}));
    repeat (2) tick();

    // fetch vs DMA contention
    ifu_req_valid = 1; ifu_req_addr = 15'h0200;
    dma_req_valid = 1; dma_req_write = 0; dma_req_addr = 15'h0300;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); pat_d[i] = dma_req_ready; pat_f[i] = ifu_req_ready;
      tick();
    end
    idle_inputs();
    chk("contend_dma", 128'(pat_d), 128'(10'h210));
    chk("contend_ifu", 128'(pat_f), 128'(10'h1EF));
    repeat (3) tick();

    // correction vs fetch
    corr_req_valid = 1; corr_req_addr = 15'h0040; corr_req_wdata = 78'h2A_5555_AAAA_0F0F_F0F0;
    ifu_req_valid = 1; ifu_req_addr = 15'h0500;
    @(negedge clk); chk("corr_win", 128'({corr_req_ready, ifu_req_ready}), 128'(2'b10));
    tick(); corr_req_valid = 0;
    @(negedge clk);
    chk("corr_wr", 128'({iccm_wren, iccm_buf_correct_ecc, iccm_correction_state, ifu_req_ready, iccm_rw_addr}),
        128'({4'b1110, 15'h0040}));
    tick();
    @(negedge clk);
    chk("corr_hold", 128'({iccm_wren, iccm_buf_correct_ecc, iccm_correction_state, ifu_req_ready}), 128'(4'b0010));
    tick();
    @(negedge clk); chk("corr_after", 128'(ifu_req_ready), 128'(1));
    tick(); idle_inputs();
    repeat (3) tick();

    // DMA write
    dma_req_valid = 1; dma_req_write = 1; dma_req_addr = 15'h0700;
    dma_req_size = 3'b010; dma_req_wdata = 78'h3_1234_5678_9ABC_DEF0;
    @(negedge clk); chk("dmaw_ready", 128'(dma_req_ready), 128'(1));
    tick(); idle_inputs();
    @(negedge clk);
    chk("dmaw_cmd", 128'({iccm_rden, iccm_wren, iccm_wr_size, iccm_wr_data}),
        128'({2'b01, 3'b010, 78'h3_1234_5678_9ABC_DEF0}));
    tick();
    @(negedge clk); chk("dmaw_norsp", 128'({ifu_rsp_valid, dma_rsp_valid}), 128'(0));
    repeat (2) tick();

    // reset with a read in flight
    ifu_req_valid = 1; ifu_req_addr = 15'h0123;
    @(negedge clk); chk("rst_fetch_ready", 128'(ifu_req_ready), 128'(1));
    tick(); ifu_req_valid = 0; rst_l = 0;
    @(negedge clk); chk("rst_rden", 128'(iccm_rden), 128'(1));
    tick(); rst_l = 1;
    @(negedge clk);
    chk("rst_outs", 128'({iccm_rden, iccm_wren, ifu_rsp_valid, dma_rsp_valid, arb_busy, iccm_rw_addr}), 128'(0));
    tick();
    @(negedge clk); chk("rst_norsp", 128'({ifu_rsp_valid, dma_rsp_valid}), 128'(0));
    tick();

    // streaming fetch
    for (int k = 0; k < 12; k++) begin
      ifu_req_valid = (k < 8);
      ifu_req_addr  = 15'(16 + k);
      @(negedge clk); pat_rden[k] = iccm_rden; pat_rsp[k] = ifu_rsp_valid;
      tick();
    end
    idle_inputs();
    chk("stream_rden", 128'(pat_rden), 128'(12'h1FE));
    chk("stream_rsp", 128'(pat_rsp), 128'(12'h3FC));

    // randomised traffic
    f_fired = 0; d_fired = 0; c_fired = 0;
    for (int n = 0; n < 3000; n++) begin
      rst_l = ($urandom_range(0, 299) != 0);
      if (!ifu_req_valid || f_fired) begin
        ifu_req_valid = ($urandom_range(0, 3) != 0);
        ifu_req_addr  = 15'($urandom());
      end
      if (!dma_req_valid || d_fired) begin
        dma_req_valid = $urandom_range(0, 1) == 1;
        dma_req_write = $urandom_range(0, 1) == 1;
        dma_req_addr  = 15'($urandom());
        dma_req_size  = 3'($urandom());
        dma_req_wdata = 78'({$urandom(), $urandom(), $urandom()});
      end
      if (!corr_req_valid || c_fired) begin
        corr_req_valid = ($urandom_range(0, 15) == 0);
        corr_req_addr  = 15'($urandom());
        corr_req_wdata = 78'({$urandom(), $urandom(), $urandom()});
      end
      @(negedge clk);
      f_fired = ifu_req_valid && ifu_req_ready;
      d_fired = dma_req_valid && dma_req_ready;
      c_fired = corr_req_valid && corr_req_ready;
      tick();
    end
    rst_l = 1; idle_inputs();
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
